// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
// Holds the FSM state encoding, default operand width and the flag legality check.
package sar_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        DONE = 2'd2
    } state_t;

    // A healthy comparator raises exactly one of gt/lt/eq.
    function automatic logic flagsOneHot(input logic gt, input logic lt, input logic eq);
        return ({gt, lt, eq} == 3'b100) || ({gt, lt, eq} == 3'b010) || ({gt, lt, eq} == 3'b001);
    endfunction

endpackage

// File: rtl/sar_search_ctrl.sv
// MSB-first binary search against an external combinational comparator.
// Returns the comparator's a operand, exiting early once equality is seen.
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STEP_W = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cmp_gt,
    input  logic              cmp_lt,
    input  logic              cmp_eq,
    output logic [WIDTH-1:0]  trial,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic              hit,
    output logic              err,
    output logic [STEP_W-1:0] steps
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MSB_CODE = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_nextState;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_trial;
    logic [WIDTH-1:0]   r_result;
    logic               r_hit;
    logic               r_err;
    logic [STEP_W-1:0]  r_steps;

    logic               w_legal;
    logic               w_lastBit;
    logic               w_finish;
    logic [WIDTH-1:0]   w_bitMask;
    logic [WIDTH-1:0]   w_nextMask;
    logic [WIDTH-1:0]   w_decided;

    assign w_legal    = flagsOneHot(cmp_gt, cmp_lt, cmp_eq);
    assign w_lastBit  = (r_idx == '0);
    assign w_finish   = !w_legal || cmp_eq || w_lastBit;
    assign w_bitMask  = WIDTH'(1) << r_idx;
    assign w_nextMask = WIDTH'(1) << (r_idx - IDX_W'(1));
    // a < trial means the bit under test overshoots and must be dropped.
    assign w_decided  = cmp_lt ? (r_trial & ~w_bitMask) : r_trial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = TEST;
            TEST:    if (w_finish) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == TEST);
        done = (r_state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= TOP_IDX;
            r_trial  <= '0;
            r_result <= '0;
            r_hit    <= 1'b0;
            r_err    <= 1'b0;
            r_steps  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_trial <= MSB_CODE;
                        r_idx   <= TOP_IDX;
                        r_hit   <= 1'b0;
                        r_err   <= 1'b0;
                        r_steps <= '0;
                    end
                end
                TEST: begin
                    r_steps <= r_steps + STEP_W'(1);
                    if (!w_legal) begin
                        r_err    <= 1'b1;
                        r_result <= r_trial;
                    end else if (cmp_eq) begin
                        r_hit    <= 1'b1;
                        r_result <= r_trial;
                    end else if (w_lastBit) begin
                        r_result <= w_decided;
                    end else begin
                        r_idx   <= r_idx - IDX_W'(1);
                        r_trial <= w_decided | w_nextMask;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign trial  = r_trial;
    assign result = r_result;
    assign hit    = r_hit;
    assign err    = r_err;
    assign steps  = r_steps;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench for sar_search_ctrl with a behavioural 4-bit comparator.
// Expected codes, step counts and trial sequences come from closed-form search arithmetic.
module tb_sar_search_ctrl;

    localparam int W = 4;
    localparam int SW = $clog2(W + 1);

    typedef struct {
        int target;
        int forceAt;
        int extraStart;
        int expResult;
        int expHit;
        int expErr;
        int expSteps;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  targetA;
    logic          forceBoth;
    logic          cmpGt;
    logic          cmpLt;
    logic          cmpEq;
    logic [W-1:0]  trial;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          hit;
    logic          err;
    logic [SW-1:0] steps;

    int nChecks;
    int nFails;
    int prevResult;

    sar_search_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmp_gt (cmpGt),
        .cmp_lt (cmpLt),
        .cmp_eq (cmpEq),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result),
        .hit    (hit),
        .err    (err),
        .steps  (steps)
    );

    // Comparator stand-in: a = targetA, b = trial; forceBoth injects an illegal gt+lt pair.
    always_comb begin
        cmpGt = forceBoth ? 1'b1 : (targetA > trial);
        cmpLt = forceBoth ? 1'b1 : (targetA < trial);
        cmpEq = forceBoth ? 1'b0 : (targetA == trial);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Search ends when the trial first equals a, i.e. after probing a's lowest set bit.
    function automatic int modelSteps(input int t);
        if (t == 0) return W;
        for (int p = 0; p < W; p++) begin
            if (((t >> p) & 1) == 1) return W - p;
        end
        return W;
    endfunction

    // Trial before comparison c: a's top c bits, then the probe bit.
    function automatic int modelTrial(input int t, input int c);
        int keep;
        keep = W - c;
        return ((t >> keep) << keep) | (1 << (keep - 1));
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int cycles;
        targetA = W'(v.target);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = (v.extraStart != 0);
        checkOutput("accept_busy", busy, 1);
        checkOutput("accept_result_held", result, prevResult);
        checkOutput("accept_hit_clr", hit, 0);
        checkOutput("accept_err_clr", err, 0);
        checkOutput("accept_steps_clr", steps, 0);
        cycles = 0;
        while (!done && cycles < 3 * W) begin
            if (busy) checkOutput("trial_seq", trial, modelTrial(v.target, cycles));
            forceBoth = (v.forceAt != 0) && (cycles == v.forceAt - 1);
            @(negedge clk);
            start = 1'b0;
            cycles++;
        end
        forceBoth = 1'b0;
        checkOutput("done_seen", done, 1);
        checkOutput("latency", cycles, v.expSteps);
        checkOutput("result", result, v.expResult);
        checkOutput("hit", hit, v.expHit);
        checkOutput("err", err, v.expErr);
        checkOutput("steps", steps, v.expSteps);
        checkOutput("done_busy_low", busy, 0);
        @(negedge clk);
        checkOutput("done_one_cycle", done, 0);
        checkOutput("idle_busy", busy, 0);
        @(negedge clk);
        checkOutput("no_relaunch", busy, 0);
        prevResult = v.expResult;
    endtask

    vec_t table_v[6];

    initial begin
        vec_t rv;
        int t;
        int waitCnt;
        nChecks    = 0;
        nFails     = 0;
        prevResult = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        targetA    = '0;
        forceBoth  = 1'b0;

        table_v[0] = '{10, 0, 0, 10, 1, 0, 3};
        table_v[1] = '{0,  0, 0, 0,  0, 0, 4};
        table_v[2] = '{15, 0, 0, 15, 1, 0, 4};
        table_v[3] = '{12, 0, 0, 12, 1, 0, 2};
        table_v[4] = '{10, 2, 0, 12, 0, 1, 2};
        table_v[5] = '{5,  0, 1, 5,  1, 0, 4};

        repeat (2) @(negedge clk);
        checkOutput("reset_trial", trial, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_result", result, 0);
        checkOutput("reset_hit", hit, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_steps", steps, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) applyStimulus(table_v[i]);

        // Reset in the middle of a search: everything clears at once, no done pulse.
        targetA = 4'd9;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_trial", trial, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_result", result, 0);
        checkOutput("midrst_hit", hit, 0);
        checkOutput("midrst_err", err, 0);
        checkOutput("midrst_steps", steps, 0);
        @(negedge clk);
        checkOutput("midrst_no_done", done, 0);
        rst_n = 1'b1;
        prevResult = 0;
        rv = '{9, 0, 0, 9, 1, 0, 4};
        applyStimulus(rv);

        // Start held high: one IDLE cycle between back-to-back searches.
        targetA = 4'd10;
        @(negedge clk);
        start = 1'b1;
        waitCnt = 0;
        while (!done && waitCnt < 3 * W) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("b2b_first_done", done, 1);
        checkOutput("b2b_first_result", result, 10);
        @(negedge clk);
        checkOutput("b2b_idle_gap", busy, 0);
        @(negedge clk);
        checkOutput("b2b_relaunch", busy, 1);
        start = 1'b0;
        waitCnt = 0;
        while (!done && waitCnt < 3 * W) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("b2b_second_done", done, 1);
        @(negedge clk);
        prevResult = 10;

        for (int i = 0; i < 20; i++) begin
            t  = int'($urandom_range(0, 15));
            rv = '{t, 0, 0, t, (t != 0) ? 1 : 0, 0, modelSteps(t)};
            applyStimulus(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
